// File: rtl/gate_sweep_checker_pkg.sv
// Shared encodings for the gate sweep checker: gate selector codes, FSM states
// and the legality check that rejects the reserved selector values.
package gate_sweep_pkg;

  localparam logic [2:0] GS_AND  = 3'b000;
  localparam logic [2:0] GS_OR   = 3'b001;
  localparam logic [2:0] GS_NAND = 3'b010;
  localparam logic [2:0] GS_NOR  = 3'b011;
  localparam logic [2:0] GS_XOR  = 3'b100;
  localparam logic [2:0] GS_XNOR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  function automatic logic is_legal_sel(input logic [2:0] sel);
    return (sel <= GS_XNOR);
  endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Bundle between the tester FSM / socket side (master) and the sweep checker (slave).
// Carries start/select, the raw device output pin, stimulus drive and held results.
interface gate_sweep_checker_if #(
  parameter int N_IN = 8
);
  logic              start;
  logic [2:0]        gate_sel;
  logic              dut_out;
  logic [N_IN-1:0]   stim;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              sel_err;
  logic [N_IN:0]     mismatch_count;
  logic [N_IN-1:0]   first_fail_vec;

  modport master (
    output start, gate_sel, dut_out,
    input  stim, busy, done, pass, fail, sel_err, mismatch_count, first_fail_vec
  );

  modport slave (
    input  start, gate_sel, dut_out,
    output stim, busy, done, pass, fail, sel_err, mismatch_count, first_fail_vec
  );
endinterface

// File: rtl/gate_sweep_checker_golden.sv
// Combinational golden model of a single-output N_IN-input gate chosen by sel.
// Reserved selector codes produce 0; callers are expected to reject them upstream.
module gate_golden_model
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic [2:0]      sel,
  input  logic [N_IN-1:0] vec,
  output logic            y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      GS_AND:  y = &vec;
      GS_OR:   y = |vec;
      GS_NAND: y = ~&vec;
      GS_NOR:  y = ~|vec;
      GS_XOR:  y = ^vec;
      GS_XNOR: y = ~^vec;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive gate tester: each vector held SETTLE_CYCLES+1 cycles, start-to-done 2^N_IN*(SETTLE_CYCLES+1)+2 cycles.
// Optional GATE_SWEEP_CONTINUOUS_EN: while start stays high, sweeps repeat back-to-back with the latched selector.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_IN          = 8,
  parameter int SETTLE_CYCLES = 50000000,
  parameter int CNT_W         = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_sweep_checker_if.slave bus
);

  localparam logic [N_IN-1:0]  LAST_VEC = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  state_t            r_state;
  logic [2:0]        r_sel_q;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dut_s1;
  logic              r_dut_s2;
  logic [N_IN-1:0]   r_stim;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic              r_sel_err;
  logic [N_IN:0]     r_mis_cnt;
  logic [N_IN-1:0]   r_first;

  logic              w_golden;
  logic              w_mismatch;

  gate_golden_model #(.N_IN(N_IN)) u_golden (
    .sel (r_sel_q),
    .vec (r_stim),
    .y   (w_golden)
  );

  assign w_mismatch = (r_dut_s2 != w_golden);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel_q   <= '0;
      r_cnt     <= '0;
      r_dut_s1  <= 1'b0;
      r_dut_s2  <= 1'b0;
      r_stim    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_sel_err <= 1'b0;
      r_mis_cnt <= '0;
      r_first   <= '0;
    end else begin
      // dut_out is an asynchronous pin; only the second flop is ever compared
      r_dut_s1 <= bus.dut_out;
      r_dut_s2 <= r_dut_s1;
      r_done   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_legal_sel(bus.gate_sel)) begin
              r_sel_q   <= bus.gate_sel;
              r_stim    <= '0;
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              r_pass    <= 1'b0;
              r_fail    <= 1'b0;
              r_sel_err <= 1'b0;
              r_mis_cnt <= '0;
              r_first   <= '0;
              r_state   <= ST_SETTLE;
            end else begin
              r_pass    <= 1'b0;
              r_fail    <= 1'b1;
              r_sel_err <= 1'b1;
              r_done    <= 1'b1;
            end
          end
        end

        ST_SETTLE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          if (w_mismatch) begin
            r_mis_cnt <= r_mis_cnt + (N_IN+1)'(1);
            if (r_mis_cnt == '0) begin
              r_first <= r_stim;
            end
          end
          if (r_stim == LAST_VEC) begin
            r_state <= ST_FINISH;
          end else begin
            r_stim  <= r_stim + N_IN'(1);
            r_cnt   <= '0;
            r_state <= ST_SETTLE;
          end
        end

        ST_FINISH: begin
          r_pass <= (r_mis_cnt == '0);
          r_fail <= (r_mis_cnt != '0);
          r_done <= 1'b1;
          r_stim <= '0;
          r_cnt  <= '0;
`ifdef GATE_SWEEP_CONTINUOUS_EN
          if (bus.start) begin
            r_mis_cnt <= '0;
            r_first   <= '0;
            r_state   <= ST_SETTLE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
`else
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
`endif
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stim           = r_stim;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.fail           = r_fail;
  assign bus.sel_err        = r_sel_err;
  assign bus.mismatch_count = r_mis_cnt;
  assign bus.first_fail_vec = r_first;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a 3-input and a 4-input instance, each fed by a truth-table device
// model, checked against expected results derived from the gate rules by counting ones.
`timescale 1ns/1ps
module tb_gate_sweep_checker;

  localparam int S  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_sweep_checker_if #(.N_IN(3)) b3();
  gate_sweep_checker_if #(.N_IN(4)) b4();

  logic [7:0]  tt3;
  logic [15:0] tt4;
  assign b3.dut_out = tt3[b3.stim];
  assign b4.dut_out = tt4[b4.stim];

  gate_sweep_checker #(.N_IN(3), .SETTLE_CYCLES(S), .CNT_W(CW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );
  gate_sweep_checker #(.N_IN(4), .SETTLE_CYCLES(S), .CNT_W(CW)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  int vecs = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Gate behaviour stated through the number of ones in the vector.
  function automatic bit ref_gate(input int sel, input int v, input int n);
    int ones;
    ones = $countones(v);
    case (sel)
      0: return ones == n;
      1: return ones != 0;
      2: return ones != n;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic ideal_table(input int which, input int sel);
    for (int v = 0; v < (1 << which); v++) begin
      if (which == 3) tt3[v] = ref_gate(sel, v, 3);
      else            tt4[v] = ref_gate(sel, v, 4);
    end
  endtask

  task automatic run(input int which, input logic [2:0] sel, input logic [2:0] alt,
                     input int toggle_at, output int cyc);
    bit got;
    @(negedge clk);
    if (which == 3) begin b3.gate_sel = sel; b3.start = 1'b1; end
    else            begin b4.gate_sel = sel; b4.start = 1'b1; end
    cyc = 0;
    got = 0;
    while (!got && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin b3.start = 1'b0; b4.start = 1'b0; end
      if (cyc == toggle_at) begin
        if (which == 3) b3.gate_sel = alt; else b4.gate_sel = alt;
      end
      got = (which == 3) ? b3.done : b4.done;
    end
    if (!got) begin
      vecs++;
      miscompares++;
      $error("FAIL timeout: no done after %0d cycles, required within 400", cyc);
    end
  endtask

  task automatic sweep_check(input string tag, input int which, input int sel,
                             input int alt, input int toggle_at);
    int cyc, cnt, first;
    bit e, d;
    cnt = 0;
    first = 0;
    for (int v = 0; v < (1 << which); v++) begin
      e = ref_gate(sel, v, which);
      d = (which == 3) ? tt3[v] : tt4[v];
      if (e != d) begin
        if (cnt == 0) first = v;
        cnt++;
      end
    end
    run(which, 3'(sel), 3'(alt), toggle_at, cyc);
    check({tag, ".latency"}, cyc, (1 << which) * (S + 1) + 2);
    if (which == 3) begin
      check({tag, ".pass"},  b3.pass, cnt == 0);
      check({tag, ".fail"},  b3.fail, cnt != 0);
      check({tag, ".selerr"}, b3.sel_err, 0);
      check({tag, ".count"}, b3.mismatch_count, cnt);
      check({tag, ".first"}, b3.first_fail_vec, first);
    end else begin
      check({tag, ".pass"},  b4.pass, cnt == 0);
      check({tag, ".fail"},  b4.fail, cnt != 0);
      check({tag, ".selerr"}, b4.sel_err, 0);
      check({tag, ".count"}, b4.mismatch_count, cnt);
      check({tag, ".first"}, b4.first_fail_vec, first);
    end
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, (which == 3) ? b3.done : b4.done, 0);
    check({tag, ".idle"}, (which == 3) ? {b3.busy, 4'(b3.stim)} : {b4.busy, b4.stim}, 0);
  endtask

  initial begin
    int cyc, k;
    b3.start = 1'b0; b3.gate_sel = 3'b000;
    b4.start = 1'b0; b4.gate_sel = 3'b000;
    tt3 = '0;
    tt4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.stim",  b3.stim, 0);
    check("rst.busy",  b3.busy, 0);
    check("rst.done",  b3.done, 0);
    check("rst.pass",  b3.pass, 0);
    check("rst.fail",  b3.fail, 0);
    check("rst.selerr", b3.sel_err, 0);
    check("rst.count", b3.mismatch_count, 0);
    check("rst.first", b3.first_fail_vec, 0);
    check("rst.b4", {b4.busy, b4.pass, b4.fail, b4.mismatch_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    ideal_table(3, 2);
    sweep_check("nand_ideal", 3, 2, 2, 0);

    tt3 = 8'hFF;
    sweep_check("nand_stuck1", 3, 2, 2, 0);

    ideal_table(4, 1);
    sweep_check("xor_vs_or", 4, 4, 4, 0);

    run(3, 3'b110, 3'b110, 0, cyc);
    check("rsv.latency", cyc, 1);
    check("rsv.fail",   b3.fail, 1);
    check("rsv.pass",   b3.pass, 0);
    check("rsv.selerr", b3.sel_err, 1);
    check("rsv.stim",   b3.stim, 0);
    check("rsv.busy",   b3.busy, 0);
    check("rsv.count_held", b3.mismatch_count, 1);
    check("rsv.first_held", b3.first_fail_vec, 7);
    @(posedge clk); #1;
    check("rsv.done_pulse", b3.done, 0);

    // Abort partway through vector 5 with a synchronous reset.
    ideal_table(3, 2);
    @(negedge clk);
    b3.gate_sel = 3'b010;
    b3.start = 1'b1;
    @(posedge clk); #1;
    b3.start = 1'b0;
    k = 0;
    while (b3.stim != 3'd5 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort.reached_vec5", b3.stim, 5);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort.stim", b3.stim, 0);
    check("abort.busy", b3.busy, 0);
    check("abort.done", b3.done, 0);
    check("abort.results", {b3.pass, b3.fail, b3.sel_err, 4'(b3.mismatch_count)}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("after_abort", 3, 2, 2, 0);

    ideal_table(3, 0);
    sweep_check("sel_toggle", 3, 0, 1, 10);

    for (int i = 0; i < 6; i++) begin
      int rs;
      rs = $urandom_range(0, 5);
      if (i % 2 == 0) ideal_table(4, rs);
      else            tt4 = 16'($urandom);
      sweep_check($sformatf("rand%0d", i), 4, rs, rs, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
